// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int unsigned MAX_WIDTH = 64;

    // LO value forced by a divide whose divisor was zero.
    localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

    // Iteration counter width for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of radix-2 shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Divide: acc = {remainder, dividend/quotient}; the guard bit is shifted[WIDTH].
    // Multiply: acc = {partial product, multiplier}; sum carries into the top bit.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (mode_div) begin
            if (diff[WIDTH]) begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_step, prod_fix;
    logic [WIDTH-1:0]     opnd_q, mag_a, mag_b, quo_fix, rem_fix;
    logic                 div_q, neg_quo, neg_rem, bzero_q;
    logic                 busy_d, done_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .operand  (opnd_q),
        .mode_div (div_q),
        .acc_next (acc_step)
    );

    assign mag_a    = (Sign && A[WIDTH-1]) ? -A : A;
    assign mag_b    = (Sign && B[WIDTH-1]) ? -B : B;
    assign prod_fix = neg_quo ? -acc_q : acc_q;
    assign quo_fix  = neg_quo ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == FIX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            case (state_q)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        div_q    <= op_div;
                        neg_quo  <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem  <= Sign & A[WIDTH-1];
                        bzero_q  <= (B == '0);
                        cnt_q    <= '0;
                        div_zero <= 1'b0;
                        if (op_div) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    // A zero divisor leaves |A| in the remainder, so hi reproduces A.
                    if (div_q) begin
                        hi       <= rem_fix;
                        lo       <= bzero_q ? DIV0_LO[WIDTH-1:0] : quo_fix;
                        div_zero <= bzero_q;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH = 32).
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk, reset_n, start, op_div, Sign, hi_we, lo_we;
    logic [W-1:0] A, B, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op_div   (op_div),
        .Sign     (Sign),
        .A        (A),
        .B        (B),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, scramble inputs after accept, wait for done and check it.
    task automatic run_op(input string tag, input logic div, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input logic exp_dz);
        int lat;
        @(negedge clk);
        start = 1'b1; op_div = div; Sign = sgn; A = a; B = b;
        @(posedge clk); #1;
        chk({tag, "_accept_busy"}, 64'(busy), 64'd1);
        chk({tag, "_dz_cleared"}, 64'(div_zero), 64'd0);
        @(negedge clk);
        start = 1'b0; op_div = ~div; Sign = ~sgn; A = ~a; B = ~b;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        chk({tag, "_div_zero"}, 64'(div_zero), 64'(exp_dz));
    endtask

    task automatic pulse_end(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_single"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [W-1:0] cap_hi, cap_lo;
        reset_n = 1'b0; start = 1'b0; op_div = 1'b0; Sign = 1'b0;
        A = '0; B = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk); reset_n = 1'b1;

        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        pulse_end("multu_max");
        run_op("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        pulse_end("mult_neg");
        run_op("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // Start in the done cycle: back-to-back accept.
        run_op("divu_b2b", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        pulse_end("divu_b2b");
        run_op("div_zero", 1'b1, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        pulse_end("div_zero");
        chk("dz_sticky", 64'(div_zero), 64'd1);
        run_op("div_zero_neg", 1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        pulse_end("div_zero_neg");
        run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        pulse_end("div_ovf");

        // MTLO / MTHI in IDLE.
        @(negedge clk); lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        chk("mtlo", {hi, lo}, {32'd0, 32'h55});
        @(negedge clk); lo_we = 1'b0; hi_we = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        chk("mthi", {hi, lo}, {32'h77, 32'h55});
        @(negedge clk); hi_we = 1'b0;

        // Start and writes while busy are dropped.
        start = 1'b1; op_div = 1'b0; Sign = 1'b0; A = 32'd6; B = 32'd7;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; A = 32'd9; B = 32'd9; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("busy_drop_hilo", {hi, lo}, {32'h77, 32'h55});
        @(negedge clk); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        ndone = 0; cap_hi = '0; cap_lo = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++; cap_hi = hi; cap_lo = lo;
            end
        end
        chk("busy_drop_ndone", 64'(ndone), 64'd1);
        chk("busy_drop_result", {cap_hi, cap_lo}, {32'd0, 32'd42});

        // Same-cycle MTHI and start: write lands, then result overwrites it.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; Sign = 1'b0; A = 32'd2; B = 32'd3;
        hi_we = 1'b1; wdata = 32'hABCD_1234;
        @(posedge clk); #1;
        chk("same_cycle_hi", 64'(hi), 64'(32'hABCD_1234));
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        ndone = 0;
        while (done !== 1'b1 && ndone < 200) begin
            @(posedge clk); #1;
            ndone++;
        end
        chk("same_cycle_result", {hi, lo}, {32'd0, 32'd6});

        run_op("multu_x2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
        pulse_end("multu_x2");

        // Reset at cycle 10 of CALC aborts with no done.
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; Sign = 1'b0; A = 32'd9; B = 32'd9;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk); reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        run_op("multu_3x5", 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        pulse_end("multu_3x5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
